// File: rtl/eggtimer_pkg.sv
// Shared types and constants for the egg-timer sequencing controller.
package eggtimer_pkg;

    // Controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Largest tens digit of the seconds field (59 -> 00).
    localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;
    // Largest value of any BCD digit.
    localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;

    // True when all four mm:ss digits are zero.
    function automatic logic bcd_all_zero(input logic [3:0] d0, input logic [3:0] d1,
                                          input logic [3:0] d2, input logic [3:0] d3);
        return (d0 == 4'd0) && (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);
    endfunction

endpackage

// File: rtl/eggtimer_ctrl_bcd_prog_reg.sv
// Two-digit BCD register with increment and clear. The tens digit wraps
// after TENS_MAX, so the same block serves seconds (00..59) and minutes (00..99).
module bcd_prog_reg
    import eggtimer_pkg::*;
#(
    parameter logic [3:0] TENS_MAX = BCD_DIGIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    logic [3:0] ones_reg;
    logic [3:0] tens_reg;

    // Clear wins over increment; the increment wraps to 00 without carrying out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_reg <= 4'd0;
            tens_reg <= 4'd0;
        end else if (clr) begin
            ones_reg <= 4'd0;
            tens_reg <= 4'd0;
        end else if (inc) begin
            if (ones_reg == BCD_DIGIT_MAX) begin
                ones_reg <= 4'd0;
                tens_reg <= (tens_reg == TENS_MAX) ? 4'd0 : tens_reg + 4'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end
    end

    assign ones = ones_reg;
    assign tens = tens_reg;

endmodule

// File: rtl/eggtimer_ctrl.sv
// Egg-timer sequencing controller: owns the programmed cook time, loads and
// gates the countdown datapath, detects 00:00 and drives a timed 1 Hz alarm.
module eggtimer_ctrl
    import eggtimer_pkg::*;
#(
    parameter int ALARM_SECS  = 10,
    parameter int ALARM_CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse_1s,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_inc_sec,
    input  logic       btn_inc_min,
    input  logic [3:0] cnt_sec,
    input  logic [3:0] cnt_tsec,
    input  logic [3:0] cnt_min,
    input  logic [3:0] cnt_tmin,
    output logic [3:0] prog_sec,
    output logic [3:0] prog_tsec,
    output logic [3:0] prog_min,
    output logic [3:0] prog_tmin,
    output logic       ctr_load,
    output logic       timer_on,
    output logic       alarm,
    output logic       running
);

    localparam logic [ALARM_CNT_W-1:0] ALARM_LAST = ALARM_CNT_W'(ALARM_SECS - 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic                   ctr_load_reg;
    logic                   alarm_reg;
    logic                   running_reg;
    logic [ALARM_CNT_W-1:0] alarm_cnt_reg;

    logic cnt_zero;
    logic prog_zero;
    logic any_btn;
    logic prog_clr;
    logic prog_inc_sec;
    logic prog_inc_min;

    assign cnt_zero  = bcd_all_zero(cnt_sec, cnt_tsec, cnt_min, cnt_tmin);
    assign prog_zero = bcd_all_zero(prog_sec, prog_tsec, prog_min, prog_tmin);
    assign any_btn   = btn_start_stop | btn_clear | btn_inc_sec | btn_inc_min;

    // Programmed time is only edited in IDLE; clear beats start_stop beats inc.
    assign prog_clr     = (state_reg == ST_IDLE) & btn_clear;
    assign prog_inc_sec = (state_reg == ST_IDLE) & ~btn_clear & ~btn_start_stop & btn_inc_sec;
    assign prog_inc_min = (state_reg == ST_IDLE) & ~btn_clear & ~btn_start_stop & btn_inc_min;

    bcd_prog_reg #(.TENS_MAX(BCD_SEC_TENS_MAX)) u_prog_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (prog_inc_sec),
        .clr   (prog_clr),
        .ones  (prog_sec),
        .tens  (prog_tsec)
    );

    bcd_prog_reg #(.TENS_MAX(BCD_DIGIT_MAX)) u_prog_min (
        .clk   (clk),
        .reset (reset),
        .inc   (prog_inc_min),
        .clr   (prog_clr),
        .ones  (prog_min),
        .tens  (prog_tmin)
    );

    // Next-state decode; clear has the highest priority in every active state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!btn_clear && btn_start_stop && !prog_zero) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (btn_clear) begin
                    state_next = ST_IDLE;
                end else if (btn_start_stop) begin
                    state_next = ST_PAUSE;
                end else if (cnt_zero) begin
                    state_next = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    state_next = ST_IDLE;
                end else if (btn_start_stop) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (any_btn) begin
                    state_next = ST_IDLE;
                end else if (pulse_1s && (alarm_cnt_reg == ALARM_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            ctr_load_reg  <= 1'b0;
            running_reg   <= 1'b0;
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ctr_load_reg <= (state_next != ST_LOAD);
            running_reg  <= (state_next == ST_RUN);
            if (state_next != ST_DONE) begin
                alarm_reg     <= 1'b0;
                alarm_cnt_reg <= '0;
            end else if ((state_reg == ST_DONE) && pulse_1s) begin
                alarm_reg     <= ~alarm_reg;
                alarm_cnt_reg <= alarm_cnt_reg + ALARM_CNT_W'(1);
            end
        end
    end

    // Countdown only ticks while running and never wraps past 00:00.
    assign timer_on = (state_reg == ST_RUN) & ~cnt_zero;
    assign ctr_load = ctr_load_reg;
    assign running  = running_reg;
    assign alarm    = alarm_reg;

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Directed bench for eggtimer_ctrl with a behavioural countdown datapath.
module tb_eggtimer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pulse_1s = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_inc_sec = 1'b0;
    logic       btn_inc_min = 1'b0;
    logic [3:0] cnt_sec = 4'd0, cnt_tsec = 4'd0, cnt_min = 4'd0, cnt_tmin = 4'd0;
    logic [3:0] prog_sec, prog_tsec, prog_min, prog_tmin;
    logic       ctr_load, timer_on, alarm, running;

    int total  = 0;
    int passed = 0;

    eggtimer_ctrl #(.ALARM_SECS(10), .ALARM_CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pulse_1s       (pulse_1s),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .btn_inc_sec    (btn_inc_sec),
        .btn_inc_min    (btn_inc_min),
        .cnt_sec        (cnt_sec),
        .cnt_tsec       (cnt_tsec),
        .cnt_min        (cnt_min),
        .cnt_tmin       (cnt_tmin),
        .prog_sec       (prog_sec),
        .prog_tsec      (prog_tsec),
        .prog_min       (prog_min),
        .prog_tmin      (prog_tmin),
        .ctr_load       (ctr_load),
        .timer_on       (timer_on),
        .alarm          (alarm),
        .running        (running)
    );

    always #5 clk = ~clk;

    // mm:ss packed as {tmin,min,tsec,sec}
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        int s;
        int mm;
        int ss;
        s = (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
        if (s > 0) s = s - 1;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Countdown datapath model: reload while ctr_load is low, else count down on enabled ticks.
    always @(posedge clk) begin
        if (!ctr_load) begin
            {cnt_tmin, cnt_min, cnt_tsec, cnt_sec} <= {prog_tmin, prog_min, prog_tsec, prog_sec};
        end else if (timer_on && pulse_1s) begin
            {cnt_tmin, cnt_min, cnt_tsec, cnt_sec} <= bcd_dec({cnt_tmin, cnt_min, cnt_tsec, cnt_sec});
        end
    end

    wire [15:0] prog_v = {prog_tmin, prog_min, prog_tsec, prog_sec};
    wire [15:0] cnt_v  = {cnt_tmin, cnt_min, cnt_tsec, cnt_sec};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0=start_stop 1=clear 2=inc_sec 3=inc_min
    task automatic press(input int which);
        btn_start_stop = (which == 0);
        btn_clear      = (which == 1);
        btn_inc_sec    = (which == 2);
        btn_inc_min    = (which == 3);
        tick();
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        btn_inc_sec    = 1'b0;
        btn_inc_min    = 1'b0;
    endtask

    // One second tick followed by a quiet cycle.
    task automatic sec_pulse();
        pulse_1s = 1'b1;
        tick();
        pulse_1s = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ctr_load", 16'(ctr_load), 16'h0);
        check("rst_running", 16'(running), 16'h0);
        check("rst_alarm", 16'(alarm), 16'h0);
        check("rst_prog", prog_v, 16'h0000);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_ctr_load", 16'(ctr_load), 16'h1);
        check("idle_timer_on", 16'(timer_on), 16'h0);

        // 1: program 02:05 and start
        press(3); press(3);
        for (int i = 0; i < 5; i++) press(2);
        check("t1_prog", prog_v, 16'h0205);
        press(0);
        check("t1_load_low", 16'(ctr_load), 16'h0);
        check("t1_load_running", 16'(running), 16'h0);
        tick();
        check("t1_load_high", 16'(ctr_load), 16'h1);
        check("t1_running", 16'(running), 16'h1);
        check("t1_cnt", cnt_v, 16'h0205);
        check("t1_timer_on", 16'(timer_on), 16'h1);
        press(1);
        check("t1_cancel", 16'(running), 16'h0);
        check("t1_cnt_hold", cnt_v, 16'h0205);
        check("t1_prog_kept", prog_v, 16'h0205);

        // 2: 00:03 runs to zero, then 10 alarm ticks
        press(1);
        check("t2_clr", prog_v, 16'h0000);
        for (int i = 0; i < 3; i++) press(2);
        press(0);
        tick();
        check("t2_cnt_load", cnt_v, 16'h0003);
        sec_pulse();
        sec_pulse();
        check("t2_cnt1", cnt_v, 16'h0001);
        pulse_1s = 1'b1;
        tick();
        pulse_1s = 1'b0;
        check("t2_cnt0", cnt_v, 16'h0000);
        check("t2_zero_timer_on", 16'(timer_on), 16'h0);
        check("t2_zero_running", 16'(running), 16'h1);
        tick();
        check("t2_done_running", 16'(running), 16'h0);
        check("t2_done_alarm", 16'(alarm), 16'h0);
        check("t2_done_timer_on", 16'(timer_on), 16'h0);
        for (int i = 1; i <= 10; i++) begin
            pulse_1s = 1'b1;
            tick();
            pulse_1s = 1'b0;
            check($sformatf("t2_alarm%0d", i), 16'(alarm), (i < 10) ? 16'(i % 2) : 16'h0);
            tick();
        end
        check("t2_prog_kept", prog_v, 16'h0003);
        check("t2_cnt_hold", cnt_v, 16'h0000);
        // Back in IDLE: start loads again
        press(0);
        check("t2_idle_start", 16'(ctr_load), 16'h0);
        tick();

        // 3: pause / resume
        check("t3_cnt", cnt_v, 16'h0003);
        sec_pulse();
        check("t3_cnt2", cnt_v, 16'h0002);
        press(2);
        check("t3_inc_ignored", prog_v, 16'h0003);
        press(0);
        check("t3_pause_running", 16'(running), 16'h0);
        check("t3_pause_timer_on", 16'(timer_on), 16'h0);
        sec_pulse();
        sec_pulse();
        check("t3_pause_hold", cnt_v, 16'h0002);
        press(0);
        check("t3_resume", 16'(running), 16'h1);
        sec_pulse();
        check("t3_resume_cnt", cnt_v, 16'h0001);

        // 5: clear beats start_stop in RUN; start with 00:00 ignored
        btn_start_stop = 1'b1;
        btn_clear      = 1'b1;
        tick();
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        check("t5_cancel_running", 16'(running), 16'h0);
        tick();
        check("t5_cancel_stay", 16'(running), 16'h0);
        check("t5_cnt_hold", cnt_v, 16'h0001);
        press(1);
        check("t5_prog_zero", prog_v, 16'h0000);
        press(0);
        check("t5_zero_start_load", 16'(ctr_load), 16'h1);
        tick();
        check("t5_zero_start_running", 16'(running), 16'h0);

        // 4: seconds wrap without carry, minutes wrap at 99
        for (int i = 0; i < 7; i++) press(3);
        for (int i = 0; i < 59; i++) press(2);
        check("t4_sec59", prog_v, 16'h0759);
        press(2);
        check("t4_sec_wrap", prog_v, 16'h0700);
        press(1);
        for (int i = 0; i < 99; i++) press(3);
        check("t4_min99", prog_v, 16'h9900);
        press(3);
        check("t4_min_wrap", prog_v, 16'h0000);
        btn_inc_sec = 1'b1;
        btn_inc_min = 1'b1;
        tick();
        btn_inc_sec = 1'b0;
        btn_inc_min = 1'b0;
        check("t4_both", prog_v, 16'h0101);

        // 6: async reset mid-run
        press(0);
        tick();
        check("t6_running", 16'(running), 16'h1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_running", 16'(running), 16'h0);
        check("t6_rst_ctr_load", 16'(ctr_load), 16'h0);
        check("t6_rst_alarm", 16'(alarm), 16'h0);
        check("t6_rst_timer_on", 16'(timer_on), 16'h0);
        check("t6_rst_prog", prog_v, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        check("t6_rel_ctr_load", 16'(ctr_load), 16'h1);
        check("t6_rel_prog", prog_v, 16'h0000);
        check("t6_rel_cnt", cnt_v, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
